// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and defaults for the ping-pong frame-buffer scan controller.
//   scan_state_e : scan state machine encoding (IDLE, VBLANK, ACTIVE)
//   buf_idx_t    : index of one of the two frame buffers
//   *_DEF        : default values for the CH, CNT_W and ADDR_W parameters
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int unsigned CH_DEF     = 3;
  localparam int unsigned CNT_W_DEF  = 10;
  localparam int unsigned ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } scan_state_e;

  typedef logic buf_idx_t;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Frame-buffer read port driven by the scan controller.
//   rd_buf  : index of the front buffer being read
//   rd_en   : read strobe into buffer rd_buf
//   rd_addr : read address, one per channel sample
//   ch_sel  : one-hot channel select, aligned with rd_en
// Modports: master (scan controller), slave (frame buffers / pixel mux).
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  buf_idx_t          rd_buf;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CH-1:0]     ch_sel;

  modport master (output rd_buf, rd_en, rd_addr, ch_sel);
  modport slave  (input  rd_buf, rd_en, rd_addr, ch_sel);

endinterface

// File: rtl/display_scan_ctrl_scan_counter.sv
// -----------------------------------------------------------------------------
// scan_counter
// Channel -> pixel -> line counter chain for one scan region.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : force all counters to zero (held while idle)
//   run_i       : advance one channel sample this cycle
//   px_last_i   : last pixel index of a line (pixels per line - 1)
//   ln_last_i   : last line index of the current region
//   ch_wrap_o   : channel counter is at CH-1
//   px_wrap_o   : pixel counter is at px_last_i
//   ln_wrap_o   : line counter is at ln_last_i
//   px_o, ln_o  : current pixel and line within the region
// All three wraps together mark the last sample of the region, after which
// the chain has returned to zero for the next region.
// -----------------------------------------------------------------------------
module scan_counter #(
  parameter int unsigned CH    = 3,
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] px_last_i,
  input  logic [CNT_W-1:0] ln_last_i,
  output logic             ch_wrap_o,
  output logic             px_wrap_o,
  output logic             ln_wrap_o,
  output logic [CNT_W-1:0] px_o,
  output logic [CNT_W-1:0] ln_o
);

  localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] px_q;
  logic [CNT_W-1:0] ln_q;

  assign ch_wrap_o = (ch_q == CH_W'(CH - 1));
  assign px_wrap_o = (px_q == px_last_i);
  assign ln_wrap_o = (ln_q == ln_last_i);
  assign px_o      = px_q;
  assign ln_o      = ln_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0;
      px_q <= '0;
      ln_q <= '0;
    end else if (clear_i) begin
      ch_q <= '0;
      px_q <= '0;
      ln_q <= '0;
    end else if (run_i) begin
      if (ch_wrap_o) begin
        ch_q <= '0;
        if (px_wrap_o) begin
          px_q <= '0;
          ln_q <= ln_wrap_o ? '0 : ln_q + CNT_W'(1);
        end else begin
          px_q <= px_q + CNT_W'(1);
        end
      end else begin
        ch_q <= ch_q + CH_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Ping-pong frame-buffer scan controller. Sequences vertical blanking then
// active lines, one colour channel per clock, and reads the front buffer.
// Buffers swap at frame end only when the back buffer has been filled.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable_i          : scan enable, sampled at frame start
//   active_px_i       : pixels per line (blanking and active lines)
//   active_ln_i       : active lines per frame
//   vb_lines_i        : vertical-blanking lines before the active lines
//   wr_done_i         : writer finished filling buffer wr_buf_o
//   wr_buf_o          : back buffer index (writer side)
//   buf_full_o        : per-buffer full flags
//   blank_o, vsync_o  : blanking level, one-cycle frame-start pulse
//   px_cnt_o, line_cnt_o : position within the current region
//   underrun_cnt_o    : repeated-frame count
//   rd_bus            : front-buffer read port (rd_buf, rd_en, rd_addr, ch_sel)
// Build option: SCAN_UNDERRUN_CNT_EN builds the saturating underrun counter;
// without it underrun_cnt_o is tied to zero.
// -----------------------------------------------------------------------------
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable_i,
  input  logic [CNT_W-1:0]    active_px_i,
  input  logic [CNT_W-1:0]    active_ln_i,
  input  logic [CNT_W-1:0]    vb_lines_i,
  input  logic                wr_done_i,
  output buf_idx_t            wr_buf_o,
  output logic [1:0]          buf_full_o,
  output logic                blank_o,
  output logic                vsync_o,
  output logic [CNT_W-1:0]    px_cnt_o,
  output logic [CNT_W-1:0]    line_cnt_o,
  output logic [15:0]         underrun_cnt_o,
  display_scan_ctrl_if.master rd_bus
);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  geo_px_q, geo_ln_q, geo_vb_q;
  buf_idx_t          rd_buf_q, rd_buf_d, wr_buf_q, wr_buf_d;
  logic [1:0]        buf_full_q, buf_full_d;
  logic              rd_en_q, rd_en_d;
  logic              blank_q, vsync_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CH-1:0]     ch_sel_q, ch_sel_d;

  logic              ch_wrap, px_wrap, ln_wrap;
  logic [CNT_W-1:0]  ln_last;
  logic              region_end, frame_end, start, swap;

  function automatic logic [CH-1:0] rotl1(input logic [CH-1:0] v);
    return CH'((v << 1) | (v >> (CH - 1)));
  endfunction

  scan_counter #(.CH(CH), .CNT_W(CNT_W)) u_scan_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == IDLE),
    .run_i     (state_q != IDLE),
    .px_last_i (geo_px_q - CNT_W'(1)),
    .ln_last_i (ln_last),
    .ch_wrap_o (ch_wrap),
    .px_wrap_o (px_wrap),
    .ln_wrap_o (ln_wrap),
    .px_o      (px_cnt_o),
    .ln_o      (line_cnt_o)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    ln_last    = ((state_q == VBLANK) ? geo_vb_q : geo_ln_q) - CNT_W'(1);
    region_end = (state_q != IDLE) && ch_wrap && px_wrap && ln_wrap;
    frame_end  = region_end && (state_q == ACTIVE);
    // A new frame follows the previous one with no gap, or leaves IDLE.
    start      = enable_i && (active_px_i != '0) && (active_ln_i != '0) &&
                 ((state_q == IDLE) || frame_end);
    // A wr_done on the frame-end cycle still counts as a full back buffer.
    swap       = frame_end && (buf_full_q[wr_buf_q] || wr_done_i);

    buf_full_d = buf_full_q;
    if (wr_done_i) buf_full_d[wr_buf_q] = 1'b1;
    if (swap)      buf_full_d[rd_buf_q] = 1'b0;
    rd_buf_d   = swap ? ~rd_buf_q : rd_buf_q;
    wr_buf_d   = swap ? ~wr_buf_q : wr_buf_q;

    state_d = state_q;
    if (start)           state_d = (vb_lines_i != '0) ? VBLANK : ACTIVE;
    else if (frame_end)  state_d = IDLE;
    else if (region_end) state_d = ACTIVE;

    rd_en_d  = (state_d == ACTIVE) && buf_full_d[rd_buf_d];
    ch_sel_d = (state_d == IDLE) ? '0 : (start ? CH'(1) : rotl1(ch_sel_q));
  end

  // NOTE: geometry latches are ordinary control registers and take the reset
  // like everything else; nothing here is left to power-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      geo_px_q   <= '0;
      geo_ln_q   <= '0;
      geo_vb_q   <= '0;
      rd_buf_q   <= 1'b1;
      wr_buf_q   <= 1'b0;
      buf_full_q <= 2'b00;
      rd_en_q    <= 1'b0;
      blank_q    <= 1'b1;
      vsync_q    <= 1'b0;
      rd_addr_q  <= '0;
      ch_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      if (start) begin
        geo_px_q <= active_px_i;
        geo_ln_q <= active_ln_i;
        geo_vb_q <= vb_lines_i;
      end
      rd_buf_q   <= rd_buf_d;
      wr_buf_q   <= wr_buf_d;
      buf_full_q <= buf_full_d;
      rd_en_q    <= rd_en_d;
      blank_q    <= ~rd_en_d;
      vsync_q    <= start;
      ch_sel_q   <= ch_sel_d;
      // Every frame, repeated or swapped, reads from address 0.
      if (frame_end || (state_q == IDLE)) rd_addr_q <= '0;
      else if (rd_en_q)                   rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end
  end

`ifdef SCAN_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  // Counts repeats of a real frame only; an empty front buffer is start-up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= '0;
    end else if (frame_end && !swap && buf_full_q[rd_buf_q] &&
                 (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_q;
`else
  assign underrun_cnt_o = '0;
`endif

  assign wr_buf_o       = wr_buf_q;
  assign buf_full_o     = buf_full_q;
  assign blank_o        = blank_q;
  assign vsync_o        = vsync_q;
  assign rd_bus.rd_buf  = rd_buf_q;
  assign rd_bus.rd_en   = rd_en_q;
  assign rd_bus.rd_addr = rd_addr_q;
  assign rd_bus.ch_sel  = ch_sel_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Self-checking bench for display_scan_ctrl (CH=3). A frame-level model keeps
// buffer flags, indices and the repeat count; each frame pushes its expected
// vsync cycle and read samples into queues that a negedge monitor consumes.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int CH     = 3;
  localparam int CNT_W  = 10;
  localparam int ADDR_W = 16;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [CNT_W-1:0] active_px, active_ln, vb_lines;
  logic             wr_done;
  buf_idx_t         wr_buf;
  logic [1:0]       buf_full;
  logic             blank, vsync;
  logic [CNT_W-1:0] px_cnt, line_cnt;
  logic [15:0]      underrun_cnt;

  display_scan_ctrl_if #(.CH(CH), .ADDR_W(ADDR_W)) rd_bus ();

  display_scan_ctrl #(.CH(CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .active_px_i    (active_px),
    .active_ln_i    (active_ln),
    .vb_lines_i     (vb_lines),
    .wr_done_i      (wr_done),
    .wr_buf_o       (wr_buf),
    .buf_full_o     (buf_full),
    .blank_o        (blank),
    .vsync_o        (vsync),
    .px_cnt_o       (px_cnt),
    .line_cnt_o     (line_cnt),
    .underrun_cnt_o (underrun_cnt),
    .rd_bus         (rd_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues
  typedef struct {
    int cyc;
    int addr;
    int ch;
    int bsel;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      vs_q[$];
  bit      sb_on = 1'b0;

  // Frame-level model
  int       cur_px, cur_ln, cur_vb;
  buf_idx_t m_rd, m_wr;
  bit [1:0] m_full;
  int       m_und;

  function automatic int exp_underrun();
`ifdef SCAN_UNDERRUN_CNT_EN
    return m_und;
`else
    return 0;
`endif
  endfunction

  // Monitor: every cycle the DUT either presents the next expected read or
  // stays blanked; vsync is high only on expected frame-start cycles.
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check("rd_en", rd_bus.rd_en, 1);
        check("blank_active", blank, 0);
        check("rd_addr", rd_bus.rd_addr, e.addr);
        check("ch_sel", rd_bus.ch_sel, e.ch);
        check("rd_buf_rd", rd_bus.rd_buf, e.bsel);
      end else begin
        check("rd_en_idle", rd_bus.rd_en, 0);
        check("blank_idle", blank, 1);
      end
      if (vs_q.size() > 0 && vs_q[0] == cyc) begin
        void'(vs_q.pop_front());
        check("vsync_hi", vsync, 1);
      end else begin
        check("vsync_lo", vsync, 0);
      end
    end
  end

  // Called #1 after the edge that starts a frame with geometry cur_*.
  task automatic run_frame(input int wr_at, input int chg_at,
                           input int npx, input int nln, input int nvb);
    int L, vb_len, k, f0;
    L      = (cur_vb + cur_ln) * cur_px * CH;
    vb_len = cur_vb * cur_px * CH;
    f0     = cyc;
    check("frm_rd_buf", rd_bus.rd_buf, m_rd);
    check("frm_wr_buf", wr_buf, m_wr);
    check("frm_buf_full", buf_full, m_full);
    check("frm_underrun", underrun_cnt, exp_underrun());
    vs_q.push_back(f0);
    if (m_full[m_rd])
      for (int i = 0; i < cur_ln * cur_px * CH; i++)
        rd_q.push_back('{cyc: f0 + vb_len + i, addr: i, ch: (1 << (i % CH)), bsel: m_rd});
    for (int j = 0; j < L; j++) begin
      k = (j < vb_len) ? j : j - vb_len;
      check("px_cnt", px_cnt, (k / CH) % cur_px);
      check("line_cnt", line_cnt, k / (CH * cur_px));
      wr_done = (j == wr_at);
      if (j == wr_at) m_full[m_wr] = 1'b1;
      if (j == chg_at) begin
        active_px = CNT_W'(npx);
        active_ln = CNT_W'(nln);
        vb_lines  = CNT_W'(nvb);
      end
      @(posedge clk);
      #1;
    end
    wr_done = 1'b0;
    if (m_full[m_wr]) begin
      m_full[m_rd] = 1'b0;
      m_rd = ~m_rd;
      m_wr = ~m_wr;
    end else if (m_full[m_rd] && m_und < 16'hFFFF) begin
      m_und++;
    end
    cur_px = npx;
    cur_ln = nln;
    cur_vb = nvb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int L, npx, nln, nvb, r, wr_at;

    rst_n     = 1'b0;
    enable    = 1'b0;
    wr_done   = 1'b0;
    active_px = 10'd0;
    active_ln = 10'd2;
    vb_lines  = 10'd1;
    m_rd = 1'b1; m_wr = 1'b0; m_full = 2'b00; m_und = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_buf", rd_bus.rd_buf, 1);
    check("rst_wr_buf", wr_buf, 0);
    check("rst_buf_full", buf_full, 0);
    check("rst_rd_en", rd_bus.rd_en, 0);
    check("rst_rd_addr", rd_bus.rd_addr, 0);
    check("rst_ch_sel", rd_bus.ch_sel, 0);
    check("rst_blank", blank, 1);
    check("rst_vsync", vsync, 0);
    check("rst_px", px_cnt, 0);
    check("rst_line", line_cnt, 0);
    check("rst_underrun", underrun_cnt, 0);
    rst_n  = 1'b1;
    sb_on  = 1'b1;

    // Zero pixel count: enabled but must stay idle and blanked.
    enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("zero_geo_blank", blank, 1);
    check("zero_geo_px", px_cnt, 0);
    active_px = 10'd4;
    @(posedge clk);
    #1;
    cur_px = 4; cur_ln = 2; cur_vb = 1;

    run_frame(-1, 0, 4, 2, 1);   // empty front: blanked frame
    run_frame( 5, 0, 4, 2, 1);   // fill back buffer, swap at end
    run_frame(-1, 0, 4, 2, 1);   // reads 0..23 from buffer 0
    run_frame(-1, 0, 4, 2, 1);   // repeat frame
    run_frame(35, 0, 4, 2, 1);   // wr_done on the frame-end cycle
    run_frame(-1, 10, 2, 2, 1);  // geometry change mid-frame
    run_frame(-1, 0, 2, 2, 1);   // 18-cycle frame

    for (int f = 0; f < 25; f++) begin
      npx = $urandom_range(1, 4);
      nln = $urandom_range(1, 3);
      nvb = $urandom_range(0, 2);
      L   = (cur_vb + cur_ln) * cur_px * CH;
      r   = $urandom_range(0, 3);
      wr_at = (r == 0) ? -1 : (r == 1) ? L - 1 : $urandom_range(0, L - 1);
      run_frame(wr_at, $urandom_range(0, L - 1), npx, nln, nvb);
    end

    sb_on = 1'b0;
    check("rd_q_drained", rd_q.size(), 0);
    check("vs_q_drained", vs_q.size(), 0);

    // Reset during active video.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (rd_bus.rd_en) found = 1'b1;
    end
    check("rst_wait_rd_en", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rd_buf", rd_bus.rd_buf, 1);
    check("arst_wr_buf", wr_buf, 0);
    check("arst_buf_full", buf_full, 0);
    check("arst_rd_en", rd_bus.rd_en, 0);
    check("arst_rd_addr", rd_bus.rd_addr, 0);
    check("arst_ch_sel", rd_bus.ch_sel, 0);
    check("arst_blank", blank, 1);
    check("arst_vsync", vsync, 0);
    check("arst_px", px_cnt, 0);
    check("arst_line", line_cnt, 0);
    check("arst_underrun", underrun_cnt, 0);
    @(posedge clk);
    #1;
    check("arst_hold_rd_en", rd_bus.rd_en, 0);
    check("arst_hold_full", buf_full, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
